pattern_serializer: RTL and testbench

Reads a byte pattern from `pattern_ram` (single-port, registered address, one-cycle read latency) and emits it as a gap-free serial bit stream at a programmable bit period. It sits directly downstream of `pattern_ram` on its address/q pins and drives one output channel of the differential-frequency serial output. Supports one-shot and continuous-repeat playback and an abort.

---
 rtl/pattern_serializer_pkg.sv | 15 +
 rtl/pattern_serializer_bit_tick_gen.sv | 34 +++
 rtl/pattern_serializer.sv | 162 ++++++++++++++++
 tb/tb_pattern_serializer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the pattern serializer: FSM state encoding and default widths.
package pattern_serializer_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDivW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift
  } ps_state_e;

endpackage

// File: rtl/pattern_serializer_bit_tick_gen.sv
// Bit-period generator: down-counter reloaded with div, ticks once per div+1 enabled cycles.
module pattern_serializer_bit_tick_gen #(
  parameter int unsigned DivW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [DivW-1:0] div_i,
  output logic            tick_o
);

  logic [DivW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !load_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? div_i : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// Streams a byte pattern from a registered-address RAM as a gap-free serial bit stream.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned DIV_W     = DefDivW,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              repeat_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic [DIV_W-1:0]  div_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic              serial_o,
  output logic              busy_o,
  output logic              done_tick_o
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  ps_state_e         state_q, state_d;
  logic              rpt_q, rpt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] pf_q, pf_d;
  logic [1:0]        pend_q, pend_d;
  logic [CntW-1:0]   bit_q, bit_d;
  logic              done_q, done_d;
  logic              tick, tick_load;
  logic [DATA_W-1:0] sr_shift;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] last);
    return (a == last) ? '0 : a + 1'b1;
  endfunction

  // Shift register is cleared whenever idle, so the output bit reads 0 outside playback.
  assign sr_shift    = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
  assign serial_o    = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];
  assign ram_addr_o  = addr_q;
  assign busy_o      = (state_q != StIdle);
  assign done_tick_o = done_q;

  pattern_serializer_bit_tick_gen #(
    .DivW (DIV_W)
  ) u_bit_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == StShift),
    .load_i (tick_load),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    rpt_d     = rpt_q;
    last_d    = last_q;
    div_d     = div_q;
    addr_d    = addr_q;
    cur_d     = cur_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    done_d    = 1'b0;
    tick_load = 1'b0;
    // RAM data for a newly presented address is valid two edges after the address changes.
    pend_d    = {pend_q[0], 1'b0};
    pf_d      = pend_q[1] ? ram_q_i : pf_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          rpt_d   = repeat_i;
          last_d  = last_addr_i;
          div_d   = div_i;
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        addr_d  = next_addr(addr_q, last_q);
        pend_d  = 2'b01;
        state_d = StLoad;
      end
      StLoad: begin
        sr_d      = ram_q_i;
        cur_d     = '0;
        bit_d     = '0;
        tick_load = 1'b1;
        state_d   = StShift;
      end
      StShift: begin
        if (tick) begin
          if (bit_q == LastBit) begin
            if (cur_q == last_q && !rpt_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
              sr_d    = '0;
              addr_d  = '0;
            end else begin
              sr_d   = pf_q;
              cur_d  = next_addr(cur_q, last_q);
              addr_d = next_addr(addr_q, last_q);
              pend_d = 2'b01;
              bit_d  = '0;
            end
          end else begin
            sr_d  = sr_shift;
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (stop_i && state_q != StIdle) begin
      state_d = StIdle;
      sr_d    = '0;
      addr_d  = '0;
      done_d  = 1'b0;
      pend_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rpt_q   <= 1'b0;
      last_q  <= '0;
      div_q   <= '0;
      addr_q  <= '0;
      cur_q   <= '0;
      sr_q    <= '0;
      pf_q    <= '0;
      pend_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rpt_q   <= rpt_d;
      last_q  <= last_d;
      div_q   <= div_d;
      addr_q  <= addr_d;
      cur_q   <= cur_d;
      sr_q    <= sr_d;
      pf_q    <= pf_d;
      pend_q  <= pend_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench: per-cycle comparison against a bit-stream model built from the RAM image.
module tb_pattern_serializer;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          repeat_i = 1'b0;
  logic [AW-1:0] last_addr_i = '0;
  logic [VW-1:0] div_i = '0;
  logic [AW-1:0] ram_addr_o;
  logic [AW-1:0] ram_addr_q = '0;
  logic [DW-1:0] ram_q;
  logic          serial_o, busy_o, done_tick_o;
  logic [DW-1:0] mem [256];

  typedef struct {
    bit s;
    bit b;
    bit d;
    bit ca;
    int a;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  bit   obs_q[$];
  int   nerr = 0;
  int   nchk = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  pattern_serializer #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DIV_W     (VW),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .repeat_i    (repeat_i),
    .last_addr_i (last_addr_i),
    .div_i       (div_i),
    .ram_addr_o  (ram_addr_o),
    .ram_q_i     (ram_q),
    .serial_o    (serial_o),
    .busy_o      (busy_o),
    .done_tick_o (done_tick_o)
  );

  always #5 clk = ~clk;

  // Registered-address RAM: q follows the address sampled at the previous edge.
  always @(posedge clk) ram_addr_q <= ram_addr_o;
  assign ram_q = mem[ram_addr_q];

  task automatic chk(input string name, input int act, input int expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input bit s, input bit b, input bit d, input bit ca, input int a);
    exp_q.push_back('{s: s, b: b, d: d, ca: ca, a: a});
  endtask

  // Bit c of the stream: each bit lasts dv+1 cycles, each word DW bits, words cycle 0..last.
  function automatic bit model_serial(input int c, input int last, input int dv);
    int            w = (c / (DW * (dv + 1))) % (last + 1);
    int            b = (c / (dv + 1)) % DW;
    logic [DW-1:0] v = mem[w];
    return v[DW-1-b];
  endfunction

  function automatic logic [15:0] pack_obs(input int from, input int n);
    logic [15:0] r = '0;
    for (int k = 0; k < n; k++) begin
      r = {r[14:0], (from + k < obs_q.size()) ? obs_q[from + k] : 1'b0};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      chk("serial", int'(serial_o), int'(cur_e.s));
      chk("busy", int'(busy_o), int'(cur_e.b));
      chk("done_tick", int'(done_tick_o), int'(cur_e.d));
      if (cur_e.ca) chk("ram_addr", int'(ram_addr_o), cur_e.a);
    end
    if (busy_o) busy_cnt++;
    if (done_tick_o) done_cnt++;
  end

  // mode: 0 one-shot to completion, 1 stop, 2 stop+start together, 3 reset mid-stream.
  task automatic play(input int last, input int dv, input bit rpt, input int ndata_in,
                      input int mode);
    int ndata;
    int i = 0;
    int guard = 0;
    ndata = (mode == 0) ? (last + 1) * DW * (dv + 1) : ndata_in;
    obs_q.delete();
    @(negedge clk);
    #1;
    repeat_i    = rpt;
    last_addr_i = AW'(last);
    div_i       = VW'(dv);
    start_i     = 1'b1;
    push(1'b0, 1'b1, 1'b0, 1'b1, 0);
    push(1'b0, 1'b1, 1'b0, 1'b1, 1 % (last + 1));
    for (int c = 0; c < ndata; c++) begin
      push(model_serial(c, last, dv), 1'b1, 1'b0, 1'b1,
           ((c / (DW * (dv + 1))) % (last + 1) + 1) % (last + 1));
    end
    if (mode == 0) begin
      push(1'b0, 1'b0, 1'b1, 1'b0, 0);
      push(1'b0, 1'b0, 1'b0, 1'b1, 0);
    end else begin
      for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b0, 1'b1, 0);
    end
    while (exp_q.size() > 0 && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
      obs_q.push_back(serial_o);
      start_i = 1'b0;
      stop_i  = 1'b0;
      if (i + 1 == 2 + ndata / 2) begin
        start_i     = 1'b1;
        div_i       = ~div_i;
        repeat_i    = ~repeat_i;
        last_addr_i = ~last_addr_i;
      end
      if (i + 1 == 2 + ndata) begin
        if (mode == 1) stop_i = 1'b1;
        if (mode == 2) begin
          stop_i  = 1'b1;
          start_i = 1'b1;
        end
        if (mode == 3) begin
          rst_n = 1'b0;
          #1;
          chk("rst_serial", int'(serial_o), 0);
          chk("rst_busy", int'(busy_o), 0);
          chk("rst_done", int'(done_tick_o), 0);
          chk("rst_addr", int'(ram_addr_o), 0);
        end
      end
      if (mode == 3 && i == 2 + ndata) rst_n = 1'b1;
      i++;
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    rst_n   = 1'b1;
    if (exp_q.size() > 0) begin
      chk("timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [15:0] m;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_serial", int'(serial_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_tick_o), 0);
    chk("reset_addr", int'(ram_addr_o), 0);
    #1 rst_n = 1'b1;

    // One-shot, two words, div 0.
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    m = '0;
    for (int c = 0; c < 16; c++) m = {m[14:0], model_serial(c, 1, 0)};
    chk("model_pin_a53c", int'(m), 16'hA53C);
    done_cnt = 0;
    play(1, 0, 1'b0, 0, 0);
    chk("t1_latency", int'(obs_q[1]), 0);
    chk("t1_first_bit", int'(obs_q[2]), 1);
    chk("t1_bits", int'(pack_obs(2, 16)), 16'hA53C);
    chk("t1_done_cnt", done_cnt, 1);

    // Same data, each bit held 4 cycles.
    busy_cnt = 0;
    play(1, 3, 1'b0, 0, 0);
    chk("t2_busy_cycles", busy_cnt, 66);
    chk("t2_first_bit_held", int'(pack_obs(2, 8)), 8'hF0);

    // Single-word repeat, stop mid-word.
    mem[0] = 8'h81;
    done_cnt = 0;
    play(0, 0, 1'b1, 27, 1);
    chk("t3_repeat_bits", int'(pack_obs(2, 16)), 16'h8181);
    chk("t3_no_done", done_cnt, 0);

    // Repeat with start+stop in the same cycle while busy.
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    done_cnt = 0;
    play(1, 1, 1'b1, 40, 2);
    chk("t5_no_done", done_cnt, 0);

    // Reset mid-word, then a fresh one-shot replays from address 0.
    play(1, 2, 1'b0, 30, 3);
    play(1, 0, 1'b0, 0, 0);
    chk("t6_replay_bits", int'(pack_obs(2, 16)), 16'hA53C);

    // Full 256-word pattern: 0xFF must be followed directly by 0x00.
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    play(255, 0, 1'b1, 256 * 8 + 12, 1);
    chk("t4_wrap_bits", int'(pack_obs(2 + 255 * 8, 16)), 16'hFF00);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
